// File: rtl/sev_seg_scan_driver_if.sv
// Bus bundle between the status/datapath logic and the seven-segment scan
// driver.
//   load       : one-cycle strobe that captures value/dp_in/blink_en
//   value      : packed hex nibbles; nibble 0 is the rightmost digit
//   dp_in      : decimal point enables, bit i is digit i (1 = lit)
//   blink_en   : per-digit blink enable
//   blank_lz   : leading-zero blanking enable (live, not latched)
//   seg        : segments gfedcba, active-low
//   dp         : decimal point, active-low
//   an         : digit anodes, active-low
//   frame_tick : one-cycle pulse at each frame wrap
// The master side drives the display data; the slave side is the driver.
interface sev_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output load, value, dp_in, blink_en, blank_lz,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  load, value, dp_in, blink_en, blank_lz,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// Value updates are held in a pending register and only take effect at a
// frame boundary so a frame never shows a mix of old and new digits.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : sev_seg_scan_driver_if slave (load/value/dp_in/blink_en/
//             blank_lz in; seg/dp/an/frame_tick out)
module sev_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  sev_seg_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BF_W-1:0]         r_blink_cnt;
  logic                    r_blink_phase;

  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blink;

  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blink;

  logic [6:0]              r_seg;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_tick;

  logic                    w_slot_wrap;
  logic                    w_frame;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_blink_bit;
  logic                    w_lz_bit;
  logic [6:0]              w_seg_n;
  logic                    w_dp_n;
  logic [NUM_DIGITS-1:0]   w_an;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h20;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_slot_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_frame     = w_slot_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= w_frame ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Blink half-period counted in whole frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame) begin
      if (r_blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BF_W'(1);
      end
    end
  end

  // Pending/committed pair. A load on the boundary edge bypasses pending
  // so the freshest value wins and nothing is left queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blink <= '0;
      r_val        <= '0;
      r_dp         <= '0;
      r_blink      <= '0;
    end else if (w_frame && bus.load) begin
      r_val        <= bus.value;
      r_dp         <= bus.dp_in;
      r_blink      <= bus.blink_en;
      r_pend_valid <= 1'b0;
    end else if (w_frame) begin
      if (r_pend_valid) begin
        r_val   <= r_pend_val;
        r_dp    <= r_pend_dp;
        r_blink <= r_pend_blink;
      end
      r_pend_valid <= 1'b0;
    end else if (bus.load) begin
      r_pend_val   <= bus.value;
      r_pend_dp    <= bus.dp_in;
      r_pend_blink <= bus.blink_en;
      r_pend_valid <= 1'b1;
    end
  end

  // Digit i is a leading zero when it and every higher nibble are zero;
  // digit 0 is never blanked.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    w_lz     = '0;
    for (int unsigned i = NUM_DIGITS; i > 1; i--) begin
      zero_run    = zero_run && (r_val[4*(i-1) +: 4] == 4'h0);
      w_lz[i-1]   = zero_run;
    end
  end

  always_comb begin
    w_nib       = '0;
    w_dp_bit    = 1'b0;
    w_blink_bit = 1'b0;
    w_lz_bit    = 1'b0;
    w_an        = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_val[4*i +: 4];
        w_dp_bit    = r_dp[i];
        w_blink_bit = r_blink[i];
        w_lz_bit    = w_lz[i];
        w_an[i]     = 1'b0;
      end
    end

    w_seg_n = hex_decode(w_nib);
    if (bus.blank_lz && w_lz_bit) begin
      w_seg_n = '1;
    end
    w_dp_n = ~w_dp_bit;
    if (r_blink_phase && w_blink_bit) begin
      w_seg_n = '1;
      w_dp_n  = 1'b1;
    end

    // First cycle of every slot is dark so the previous digit does not ghost.
    if (r_cnt == '0) begin
      w_an    = '1;
      w_seg_n = '1;
      w_dp_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg        <= '1;
      r_dp_n       <= 1'b1;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_n;
      r_dp_n       <= w_dp_n;
      r_an         <= w_an;
      r_frame_tick <= w_frame;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp_n;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Bench for sev_seg_scan_driver (4 digits, 4 cycles per slot, blink every
// 2 frames). Expected outputs come from a frame-level model: position since
// reset release gives slot/digit/frame, the displayed value for a frame is
// the last load sampled at or before that frame's opening boundary, and the
// blink phase is (frame / BLINK_FRAMES) mod 2.
module tb_sev_seg_scan_driver;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FR = N * RD;

  typedef struct {
    int          edge_n;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
  } load_t;

  logic clk;
  logic reset_n;

  sev_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  sev_seg_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total;
  int    bad;
  int    k;
  load_t loads[$];
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h20, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  function automatic void model(input int kk, input logic blz,
                                output logic [6:0] s, output logic d,
                                output logic [3:0] a, output logic ft);
    int          p;
    int          cnt;
    int          idx;
    int          f;
    int          upper;
    logic [15:0] v;
    logic [3:0]  dd;
    logic [3:0]  bb;
    p   = kk - 1;
    cnt = p % RD;
    idx = (p / RD) % N;
    f   = p / FR;
    v   = '0;
    dd  = '0;
    bb  = '0;
    for (int j = loads.size() - 1; j >= 0; j--) begin
      if (loads[j].edge_n <= f * FR) begin
        v  = loads[j].v;
        dd = loads[j].d;
        bb = loads[j].b;
        break;
      end
    end
    ft = (kk % FR == 0);
    if (cnt == 0) begin
      s = 7'h7F;
      d = 1'b1;
      a = 4'hF;
    end else begin
      a      = 4'hF;
      a[idx] = 1'b0;
      upper  = int'(v) >> (4 * idx);
      s      = (blz && idx != 0 && upper == 0) ? 7'h7F : glyph[upper & 15];
      d      = ~dd[idx];
      if ((f / BF) % 2 == 1 && bb[idx]) begin
        s = 7'h7F;
        d = 1'b1;
      end
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    check({tag, "_dp"},  32'(bus.dp), 32'h1);
    check({tag, "_an"},  32'(bus.an), 32'hF);
    check({tag, "_ft"},  32'(bus.frame_tick), 32'h0);
  endtask

  // One clock: record any load sampled on this edge, then check outputs.
  task automatic step();
    logic        l;
    logic        blz;
    load_t       ld;
    logic [6:0]  es;
    logic        ed;
    logic [3:0]  ea;
    logic        eft;
    l   = bus.load;
    blz = bus.blank_lz;
    ld.v = bus.value;
    ld.d = bus.dp_in;
    ld.b = bus.blink_en;
    @(posedge clk);
    k++;
    if (l) begin
      ld.edge_n = k;
      loads.push_back(ld);
    end
    #1;
    model(k, blz, es, ed, ea, eft);
    check("seg", 32'(bus.seg), 32'(es));
    check("dp",  32'(bus.dp), 32'(ed));
    check("an",  32'(bus.an), 32'(ea));
    check("frame_tick", 32'(bus.frame_tick), 32'(eft));
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < FR && (k % FR) != phase; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus.value    = v;
    bus.dp_in    = d;
    bus.blink_en = b;
    bus.load     = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    reset_n      = 1'b0;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.blink_en = '0;
    bus.blank_lz = 1'b0;

    // Reset and first scan of the all-zero value.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;
    run(40);

    // Mid-frame load, commits at the following boundary.
    run_until(5);
    do_load(16'h12AF, 4'h0, 4'h0);
    run(40);

    // Double load then a load on the boundary edge itself.
    run_until(1);
    do_load(16'h1111, 4'h0, 4'h0);
    run(2);
    do_load(16'h2222, 4'h0, 4'h0);
    run_until(FR - 1);
    do_load(16'h3333, 4'h0, 4'h0);
    run(36);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    do_load(16'h0040, 4'h0, 4'h0);
    run(40);
    do_load(16'h0000, 4'h0, 4'h0);
    run(40);

    // Blink on digit 1, decimal point on digit 2.
    do_load(16'h1234, 4'b0100, 4'b0010);
    run(FR * 6);
    bus.blank_lz = 1'b0;

    // Random traffic with a bias towards leading zeros.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 23) == 0) begin
        int          nz;
        logic [15:0] rv;
        nz = $urandom_range(0, 4);
        rv = 16'($urandom);
        rv = (nz == 4) ? 16'h0 : (rv & (16'hFFFF >> (4 * nz)));
        bus.value    = rv;
        bus.dp_in    = 4'($urandom);
        bus.blink_en = 4'($urandom);
        bus.load     = 1'b1;
      end
      step();
    end

    // Asynchronous reset at digit 2, cnt 2, with no clock edge in between.
    run_until(2 * RD + 2);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    k = 0;
    loads.delete();
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
